// File: rtl/dla_axi_rd_burst_splitter.sv
// dla_axi_rd_burst_splitter
// Splits a DMA read request (start address + beat count) into AXI4 INCR
// read-address bursts. Each burst is clipped to MAX_BURST_BEATS and never
// crosses a 4 KB page. All outputs are registered.
//
// Internally r_cur/r_rem hold the address and beat count *after* the burst
// currently presented on AR. The next burst is therefore computed straight
// from registers, which keeps the critical path to the clip logic alone.

module dla_axi_rd_burst_splitter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int REQ_BEATS_WIDTH = 24,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       i_sclr,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [REQ_BEATS_WIDTH-1:0] i_req_beats,
    output logic                       o_ar_valid,
    input  logic                       i_ar_ready,
    output logic [ADDR_WIDTH-1:0]      o_ar_addr,
    output logic [7:0]                 o_ar_len,
    output logic [2:0]                 o_ar_size,
    output logic [1:0]                 o_ar_burst,
    output logic                       o_ar_last
);

    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
    // Wide enough to compare the request count, the page limit (<= 4096)
    // and the burst limit (<= 256) without truncation.
    localparam int CNT_W          = (REQ_BEATS_WIDTH > 13) ? REQ_BEATS_WIDTH : 13;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES_PER_BEAT - 1);

    if ((MAX_BURST_BEATS < 1) || (MAX_BURST_BEATS > 256)) begin : g_bad_max_burst
        $error("MAX_BURST_BEATS must be in 1..256");
    end
    if ((DATA_WIDTH < 8) || (DATA_WIDTH > 1024) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
        $error("DATA_WIDTH must be a power of two in 8..1024");
    end
    if (ADDR_WIDTH < 13) begin : g_bad_addr_width
        $error("ADDR_WIDTH must be at least 13 to express a 4 KB page");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_req_ready;
    logic                       r_ar_valid;
    logic [ADDR_WIDTH-1:0]      r_ar_addr;
    logic [7:0]                 r_ar_len;
    logic                       r_ar_last;
    logic [ADDR_WIDTH-1:0]      r_cur;
    logic [REQ_BEATS_WIDTH-1:0] r_rem;

    logic                       w_req_ready_nxt;
    logic                       w_ar_valid_nxt;
    logic [ADDR_WIDTH-1:0]      w_ar_addr_nxt;
    logic [7:0]                 w_ar_len_nxt;
    logic                       w_ar_last_nxt;
    logic [ADDR_WIDTH-1:0]      w_cur_nxt;
    logic [REQ_BEATS_WIDTH-1:0] w_rem_nxt;

    logic                       w_req_hs;
    logic                       w_ar_hs;
    logic [ADDR_WIDTH-1:0]      w_src_addr;
    logic [REQ_BEATS_WIDTH-1:0] w_src_rem;
    logic [12:0]                w_to4k;
    logic [8:0]                 w_beats;
    logic [7:0]                 w_len;
    logic                       w_last;
    logic [ADDR_WIDTH-1:0]      w_after_addr;
    logic [REQ_BEATS_WIDTH-1:0] w_after_rem;

    // Clip a burst to the smallest of: beats remaining, burst limit, beats left in the page.
    function automatic logic [8:0] f_clip_beats(input logic [REQ_BEATS_WIDTH-1:0] rem,
                                                input logic [12:0]                to4k);
        logic [CNT_W-1:0] b;
        logic [CNT_W-1:0] lim;
        logic [CNT_W-1:0] pg;
        b   = CNT_W'(rem);
        lim = CNT_W'(MAX_BURST_BEATS);
        pg  = CNT_W'(to4k);
        if (lim < b) b = lim;
        if (pg < b)  b = pg;
        return 9'(b);
    endfunction

    assign w_req_hs = i_req_valid & r_req_ready;
    assign w_ar_hs  = r_ar_valid & i_ar_ready;

    // Burst source: the new request while idle, otherwise the post-burst cursor.
    assign w_src_addr   = (r_state == S_IDLE) ? (i_req_addr & ~ALIGN_MASK) : r_cur;
    assign w_src_rem    = (r_state == S_IDLE) ? i_req_beats : r_rem;

    assign w_to4k       = (13'h1000 - {1'b0, w_src_addr[11:0]}) >> SIZE_LOG2;
    assign w_beats      = f_clip_beats(w_src_rem, w_to4k);
    assign w_len        = 8'(w_beats - 9'd1);
    assign w_last       = (CNT_W'(w_beats) == CNT_W'(w_src_rem));
    assign w_after_addr = w_src_addr + (ADDR_WIDTH'(w_beats) << SIZE_LOG2);
    assign w_after_rem  = w_src_rem - REQ_BEATS_WIDTH'(w_beats);

    // Next-state and next-output logic; everything holds unless a handshake moves it.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_ar_valid_nxt  = r_ar_valid;
        w_ar_addr_nxt   = r_ar_addr;
        w_ar_len_nxt    = r_ar_len;
        w_ar_last_nxt   = r_ar_last;
        w_cur_nxt       = r_cur;
        w_rem_nxt       = r_rem;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (w_req_hs && (i_req_beats != '0)) begin
                    w_state_nxt     = S_ISSUE;
                    w_req_ready_nxt = 1'b0;
                    w_ar_valid_nxt  = 1'b1;
                    w_ar_addr_nxt   = w_src_addr;
                    w_ar_len_nxt    = w_len;
                    w_ar_last_nxt   = w_last;
                    w_cur_nxt       = w_after_addr;
                    w_rem_nxt       = w_after_rem;
                end
            end
            S_ISSUE: begin
                if (w_ar_hs) begin
                    if (r_ar_last) begin
                        w_state_nxt     = S_IDLE;
                        w_ar_valid_nxt  = 1'b0;
                        w_req_ready_nxt = 1'b1;
                    end else begin
                        w_ar_addr_nxt   = w_src_addr;
                        w_ar_len_nxt    = w_len;
                        w_ar_last_nxt   = w_last;
                        w_cur_nxt       = w_after_addr;
                        w_rem_nxt       = w_after_rem;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered request-ready and AR channel outputs.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_req_ready <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_ar_addr   <= '0;
            r_ar_len    <= '0;
            r_ar_last   <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_ar_valid  <= w_ar_valid_nxt;
            r_ar_addr   <= w_ar_addr_nxt;
            r_ar_len    <= w_ar_len_nxt;
            r_ar_last   <= w_ar_last_nxt;
        end
    end

    // Post-burst cursor; always reloaded from the request before it is read.
    always_ff @(posedge clk) begin
        r_cur <= w_cur_nxt;
        r_rem <= w_rem_nxt;
    end

    assign o_req_ready = r_req_ready;
    assign o_ar_valid  = r_ar_valid;
    assign o_ar_addr   = r_ar_addr;
    assign o_ar_len    = r_ar_len;
    assign o_ar_last   = r_ar_last;
    assign o_ar_size   = 3'(SIZE_LOG2);
    assign o_ar_burst  = 2'b01;

endmodule

// File: tb/tb_dla_axi_rd_burst_splitter.sv
// Testbench for dla_axi_rd_burst_splitter.
// Two instances: A uses the default parameters, B uses DATA_WIDTH=128 and
// MAX_BURST_BEATS=256. A select flag routes the shared stimulus to one of
// them and muxes its outputs back for checking against a queue of bursts
// computed from the splitting rules.

module tb_dla_axi_rd_burst_splitter;

    localparam int AW  = 32;
    localparam int RBW = 24;

    logic           clk = 1'b0;
    logic           sclr;
    logic           req_valid;
    logic           ar_ready;
    logic           sel;
    logic [AW-1:0]  req_addr;
    logic [RBW-1:0] req_beats;

    logic           a_req_ready, b_req_ready;
    logic           a_ar_valid,  b_ar_valid;
    logic [AW-1:0]  a_ar_addr,   b_ar_addr;
    logic [7:0]     a_ar_len,    b_ar_len;
    logic [2:0]     a_ar_size,   b_ar_size;
    logic [1:0]     a_ar_burst,  b_ar_burst;
    logic           a_ar_last,   b_ar_last;

    logic           ob_req_ready;
    logic           ob_ar_valid;
    logic [AW-1:0]  ob_ar_addr;
    logic [7:0]     ob_ar_len;
    logic [2:0]     ob_ar_size;
    logic [1:0]     ob_ar_burst;
    logic           ob_ar_last;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic          last;
    } burst_t;

    burst_t exp_q[$];
    int     n_vec;
    int     n_err;

    always #5 clk = ~clk;

    dla_axi_rd_burst_splitter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(512), .REQ_BEATS_WIDTH(RBW), .MAX_BURST_BEATS(16)
    ) u_dut_a (
        .clk(clk), .i_sclr(sclr),
        .i_req_valid(req_valid & ~sel), .o_req_ready(a_req_ready),
        .i_req_addr(req_addr), .i_req_beats(req_beats),
        .o_ar_valid(a_ar_valid), .i_ar_ready(ar_ready & ~sel),
        .o_ar_addr(a_ar_addr), .o_ar_len(a_ar_len), .o_ar_size(a_ar_size),
        .o_ar_burst(a_ar_burst), .o_ar_last(a_ar_last)
    );

    dla_axi_rd_burst_splitter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(128), .REQ_BEATS_WIDTH(RBW), .MAX_BURST_BEATS(256)
    ) u_dut_b (
        .clk(clk), .i_sclr(sclr),
        .i_req_valid(req_valid & sel), .o_req_ready(b_req_ready),
        .i_req_addr(req_addr), .i_req_beats(req_beats),
        .o_ar_valid(b_ar_valid), .i_ar_ready(ar_ready & sel),
        .o_ar_addr(b_ar_addr), .o_ar_len(b_ar_len), .o_ar_size(b_ar_size),
        .o_ar_burst(b_ar_burst), .o_ar_last(b_ar_last)
    );

    assign ob_req_ready = sel ? b_req_ready : a_req_ready;
    assign ob_ar_valid  = sel ? b_ar_valid  : a_ar_valid;
    assign ob_ar_addr   = sel ? b_ar_addr   : a_ar_addr;
    assign ob_ar_len    = sel ? b_ar_len    : a_ar_len;
    assign ob_ar_size   = sel ? b_ar_size   : a_ar_size;
    assign ob_ar_burst  = sel ? b_ar_burst  : a_ar_burst;
    assign ob_ar_last   = sel ? b_ar_last   : a_ar_last;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t sel=%0d)", tag, act, exp, $time, sel);
        end
    endtask

    // Expected burst list for a request, from plain page/limit arithmetic.
    task automatic build_exp(input logic [AW-1:0] addr, input int beats);
        int            bpb;
        int            mx;
        int            rem;
        int            to4k;
        int            b;
        logic [AW-1:0] cur;
        burst_t        e;
        bpb = sel ? 16 : 64;
        mx  = sel ? 256 : 16;
        cur = addr & ~AW'(bpb - 1);
        rem = beats;
        exp_q.delete();
        while (rem > 0) begin
            to4k = (4096 - int'(cur % 4096)) / bpb;
            b = rem;
            if (mx < b)   b = mx;
            if (to4k < b) b = to4k;
            e.addr = cur;
            e.len  = 8'(b - 1);
            e.last = (b == rem);
            exp_q.push_back(e);
            cur = cur + AW'(b * bpb);
            rem = rem - b;
        end
    endtask

    task automatic chk_burst(input int i);
        chk("ar_valid", 64'(ob_ar_valid), 64'(1));
        chk("ar_addr",  64'(ob_ar_addr),  64'(exp_q[i].addr));
        chk("ar_len",   64'(ob_ar_len),   64'(exp_q[i].len));
        chk("ar_last",  64'(ob_ar_last),  64'(exp_q[i].last));
        chk("ar_size",  64'(ob_ar_size),  sel ? 64'(4) : 64'(6));
        chk("ar_burst", 64'(ob_ar_burst), 64'(1));
    endtask

    // Issue one request and follow all its bursts; stall < 0 picks random stalls.
    task automatic run_req(input logic [AW-1:0] addr, input int beats, input int stall);
        int to;
        build_exp(addr, beats);
        to = 0;
        while (!ob_req_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk("req_ready_wait", 64'(ob_req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        req_beats = RBW'(beats);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_q.size() == 0) begin
            chk("zero_ar_valid",  64'(ob_ar_valid),  64'(0));
            chk("zero_req_ready", 64'(ob_req_ready), 64'(1));
        end else begin
            chk("busy_req_ready", 64'(ob_req_ready), 64'(0));
            for (int i = 0; i < exp_q.size(); i++) begin
                int k;
                k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                ar_ready = (k == 0);
                chk_burst(i);
                for (int s = 0; s < k; s++) begin
                    @(negedge clk);
                    chk_burst(i);
                end
                ar_ready = 1'b1;
                @(negedge clk);
            end
            chk("done_ar_valid",  64'(ob_ar_valid),  64'(0));
            chk("done_req_ready", 64'(ob_req_ready), 64'(1));
            @(negedge clk);
            chk("idle_ar_valid",  64'(ob_ar_valid),  64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        sclr      = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        ar_ready  = 1'b0;
        req_addr  = '0;
        req_beats = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(ob_req_ready), 64'(0));
        chk("rst_ar_valid",  64'(ob_ar_valid),  64'(0));
        chk("rst_ar_addr",   64'(ob_ar_addr),   64'(0));
        chk("rst_ar_len",    64'(ob_ar_len),    64'(0));
        chk("rst_ar_last",   64'(ob_ar_last),   64'(0));
        sclr = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 64'(ob_req_ready), 64'(1));

        // Directed cases on instance A
        run_req(32'h0000_0000, 40, 0);
        run_req(32'h0000_0F80, 5, 0);
        run_req(32'h0000_0040, 0, 0);
        run_req(32'h0000_0080, 0, 0);
        run_req(32'h0000_1234, 1, 0);
        run_req(32'h0000_0000, 20, 5);

        // Back-to-back zero-beat requests: ready must never drop
        req_valid = 1'b1;
        req_beats = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'($urandom);
            @(negedge clk);
            chk("zero_b2b_ready", 64'(ob_req_ready), 64'(1));
            chk("zero_b2b_valid", 64'(ob_ar_valid),  64'(0));
        end
        req_valid = 1'b0;

        // Reset in the middle of a long request
        build_exp(32'h0, 64);
        req_valid = 1'b1;
        req_addr  = '0;
        req_beats = RBW'(64);
        ar_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk_burst(0);
        @(negedge clk);
        chk_burst(1);
        sclr     = 1'b1;
        ar_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_ar_valid",  64'(ob_ar_valid),  64'(0));
        chk("mid_rst_req_ready", 64'(ob_req_ready), 64'(0));
        sclr = 1'b0;
        @(negedge clk);
        chk("mid_rel_req_ready", 64'(ob_req_ready), 64'(1));
        chk("mid_rel_ar_valid",  64'(ob_ar_valid),  64'(0));
        run_req(32'h0000_2000, 1, 0);

        // Random requests on instance A
        for (int t = 0; t < 25; t++) begin
            run_req(AW'($urandom), int'($urandom_range(0, 80)), -1);
        end

        // Instance B: address wrap, large bursts, random traffic
        sel = 1'b1;
        @(negedge clk);
        run_req(32'hFFFF_FFF0, 2, 0);
        run_req(32'h0000_0000, 300, 1);
        for (int t = 0; t < 15; t++) begin
            run_req(AW'($urandom), int'($urandom_range(0, 300)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dla_axi_rd_burst_splitter.md
# dla_axi_rd_burst_splitter

Converts a DMA read request (start address plus beat count) into a sequence of legal AXI4 read-address (AR) bursts. It sits directly upstream of the DLA AXI crossbar master port, feeding its AR channel. Bursts use the shared AXI field widths: 8-bit length, 3-bit size, 2-bit type. Bursts are clipped to `MAX_BURST_BEATS` and never cross a 4 KB boundary.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 512: AXI data width in bits. Power of two, 8..1024. `BYTES_PER_BEAT = DATA_WIDTH/8`.
- `REQ_BEATS_WIDTH`, 24: width of the request beat count.
- `MAX_BURST_BEATS`, 16: maximum beats per burst, 1..256. Elaboration error outside this range.

Ports (one clock; reset is synchronous, active-high):
- `clk`  in  1  clock.
- `i_sclr`  in  1  synchronous active-high reset.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request ready; registered.
- `i_req_addr`  in  ADDR_WIDTH  start byte address.
- `i_req_beats`  in  REQ_BEATS_WIDTH  number of beats to read; 0 is legal.
- `o_ar_valid`  out  1  AR valid.
- `i_ar_ready`  in  1  AR ready.
- `o_ar_addr`  out  ADDR_WIDTH  burst start address; low log2(BYTES_PER_BEAT) bits always 0.
- `o_ar_len`  out  8  beats minus 1.
- `o_ar_size`  out  3  constant log2(BYTES_PER_BEAT).
- `o_ar_burst`  out  2  constant 2'b01 (INCR).
- `o_ar_last`  out  1  sideband; high on the final burst of a request.

## Operation
- States: IDLE and ISSUE.
- **IDLE**
  - `o_req_ready` = 1. Handshake is `i_req_valid & o_req_ready`.
  - On handshake, latch the remaining beat count `rem = i_req_beats` and the current address `cur = i_req_addr` with its low alignment bits forced to 0.
  - If `i_req_beats == 0`: no burst is issued and the block stays in IDLE. `o_req_ready` stays 1.
  - Otherwise: register the first burst, deassert `o_req_ready`, and go to ISSUE.
- **Burst computation** (from `cur`/`rem`):
  - `to4k = (4096 - cur[11:0]) / BYTES_PER_BEAT`.
  - `beats = min(rem, MAX_BURST_BEATS, to4k)`.
  - `o_ar_len = beats - 1`.
  - `o_ar_last = (beats == rem)`.
- **ISSUE**
  - `o_ar_valid` = 1.
  - On `o_ar_valid & i_ar_ready`:
    - `cur += beats*BYTES_PER_BEAT`, wrapping modulo 2^ADDR_WIDTH.
    - `rem -= beats`.
    - If the handshaken burst had `o_ar_last`, return to IDLE. Otherwise register the next burst.
- **AXI stability rule:** while `o_ar_valid` is high and `i_ar_ready` is low, all `o_ar_*` outputs hold stable.
- `o_ar_valid` does not depend combinationally on `i_ar_ready`.
- **Reset:**
  - `i_sclr` forces state IDLE.
  - `o_req_ready` = 0, `o_ar_valid` = 0, `o_ar_addr` = 0, `o_ar_len` = 0, `o_ar_last` = 0.
  - `o_ar_size` and `o_ar_burst` are constants.
  - Reset mid-request drops the remaining bursts; no partial burst is emitted afterwards.
  - `o_req_ready` rises the first cycle after `i_sclr` deasserts.

## Timing
- Request handshake in cycle N → first `o_ar_valid` in cycle N+1, with all AR fields valid.
- With `i_ar_ready` held high, bursts issue back-to-back, one per cycle.
- Final AR handshake in cycle M → `o_ar_valid` = 0 and `o_req_ready` = 1 in cycle M+1.
- Zero-beat request: `o_req_ready` stays 1, so back-to-back zero requests are accepted every cycle.
- All outputs are registered. The burst computation is the critical combinational path: 12-bit subtract, constant shift, two compares.

## Test plan
- **Basic split.** Defaults; addr 0x0, beats 40, `i_ar_ready` held 1.
  - Three bursts: (0x000, len 15), (0x400, len 15), (0x800, len 7).
  - `o_ar_last` high only on the third burst.
  - First valid 1 cycle after the handshake; `o_req_ready` back 1 cycle after the last burst.
- **4 KB crossing.** addr 0xF80, beats 5.
  - Bursts (0xF80, len 1), then (0x1000, len 2, last).
- **Zero and unaligned.**
  - beats 0 → no `o_ar_valid`; `o_req_ready` stays 1.
  - addr 0x1234, beats 1 → single burst (0x1200, len 0, last).
  - `o_ar_size` = 6 and `o_ar_burst` = 1 throughout.
- **Backpressure.** addr 0x0, beats 20; `i_ar_ready` low for 5 cycles on each burst.
  - AR fields stable while stalled.
  - Bursts (0x000, len 15), then (0x400, len 3, last).
  - No extra or duplicate bursts.
- **Reset mid-request.** beats 64; assert `i_sclr` after the first burst handshake.
  - Next cycle `o_ar_valid` = 0 and `o_req_ready` = 0.
  - `o_req_ready` = 1 the cycle after release.
  - A new request (addr 0x2000, beats 1) yields exactly one burst (0x2000, len 0).
- **Address wrap and max burst.** `ADDR_WIDTH`=32, `MAX_BURST_BEATS`=256, `DATA_WIDTH`=128; addr 0xFFFFFFF0, beats 2.
  - Bursts (0xFFFFFFF0, len 0), then (0x00000000, len 0, last).
